// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding, defaults and line levels
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int   DEF_OVERSAMPLE = 16;
    localparam int   DEF_DATA_W     = 8;
    localparam logic LINE_IDLE      = 1'b1;

endpackage

// File: rtl/uart_tx_bit_timer.sv
// rtl/uart_tx_bit_timer.sv - bit-period counter, one bit or the full stop period
module uart_tx_bit_timer #(
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1,
    localparam int TW        = $clog2(OVERSAMPLE * STOP_BITS)
) (
    input  logic          clk,
    input  logic          rst_,
    input  logic          clear,
    input  logic          len_sel,
    output logic [TW-1:0] count,
    output logic          last_cycle
);

    localparam logic [TW-1:0] BIT_LAST  = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] STOP_LAST = TW'(OVERSAMPLE * STOP_BITS - 1);

    always_comb begin
        last_cycle = len_sel ? (count == STOP_LAST) : (count == BIT_LAST);
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            count <= '0;
        end else if (clear || last_cycle) begin
            count <= '0;
        end else begin
            count <= count + TW'(1);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART transmitter with one-entry holding register
module uart_tx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = DEF_OVERSAMPLE,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int STOP_BITS  = 1
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic              tx,
    output logic              busy_o,
    output logic              done_o
);

    localparam int TW = $clog2(OVERSAMPLE * STOP_BITS);
    localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [TW-1:0] DONE_AT  = TW'(OVERSAMPLE * STOP_BITS - 2);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_W - 1);

    uart_state_t       state;
    logic [DATA_W-1:0] hold_data;
    logic              hold_valid;
    logic [DATA_W-1:0] shift;
    logic [IW-1:0]     bit_idx;
    logic [TW-1:0]     count;
    logic              last_cycle;
    logic              accept;
    logic              direct;
    logic              drain;

    uart_tx_bit_timer #(
        .OVERSAMPLE (OVERSAMPLE),
        .STOP_BITS  (STOP_BITS)
    ) u_timer (
        .clk        (clk),
        .rst_       (rst_),
        .clear      (state == IDLE),
        .len_sel    (state == STOP),
        .count      (count),
        .last_cycle (last_cycle)
    );

    // An accept while idle bypasses the hold register so the start bit appears next cycle.
    always_comb begin
        accept = valid_i && ready_o;
        direct = accept && (state == IDLE);
        drain  = hold_valid && ((state == IDLE) || ((state == STOP) && last_cycle));
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state      <= IDLE;
            tx         <= LINE_IDLE;
            ready_o    <= 1'b1;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            hold_valid <= 1'b0;
            hold_data  <= '0;
            shift      <= '0;
            bit_idx    <= '0;
        end else begin
            done_o <= (state == STOP) && (count == DONE_AT);

            if (accept && !direct) begin
                hold_valid <= 1'b1;
                hold_data  <= data_i;
                ready_o    <= 1'b0;
            end else if (drain) begin
                hold_valid <= 1'b0;
                ready_o    <= 1'b1;
            end

            case (state)
                IDLE: begin
                    tx <= LINE_IDLE;
                    if (direct || hold_valid) begin
                        shift  <= direct ? data_i : hold_data;
                        state  <= START;
                        tx     <= 1'b0;
                        busy_o <= 1'b1;
                    end
                end
                START: begin
                    if (last_cycle) begin
                        state   <= DATA;
                        tx      <= shift[0];
                        bit_idx <= '0;
                    end
                end
                DATA: begin
                    if (last_cycle) begin
                        if (bit_idx == IDX_LAST) begin
                            state <= STOP;
                            tx    <= LINE_IDLE;
                        end else begin
                            shift   <= shift >> 1;
                            tx      <= shift[1];
                            bit_idx <= bit_idx + IW'(1);
                        end
                    end
                end
                STOP: begin
                    if (last_cycle) begin
                        if (hold_valid) begin
                            shift <= hold_data;
                            state <= START;
                            tx    <= 1'b0;
                        end else begin
                            state  <= IDLE;
                            busy_o <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
